uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer between the UART RX engine and the TramelBlaze port-0 read path. It drains each completed character from the RX engine, together with its parity and framing flags, into a first-word-fall-through FIFO. It then presents the oldest entry to the processor, so that bursts of characters do not overrun the engine's single holding register. It also raises a one-cycle interrupt request when the buffer goes from empty to non-empty.

## Interface
- DEPTH, 16, number of entries; power of two, ≥ 2
- WIDTH, 8, character width in bits
- clk  input  1  100 MHz system clock
- reset  input  1  asynchronous, active-high reset; internal flops clear immediately on assertion
- rx_data  input  WIDTH  character from RX engine (UART_RDATA)
- rx_perr  input  1  RX engine parity error for rx_data
- rx_ferr  input  1  RX engine framing error for rx_data
- rxrdy  input  1  RX engine ready level; stays high until acknowledged
- rx_read  output  1  one-cycle acknowledge to RX engine; wired as its READS0
- pop  input  1  processor read of port 0 (PORT_ID==0 && READ_STROBE)
- head_data  output  WIDTH  oldest entry's character; 0 when empty
- head_perr  output  1  oldest entry's parity flag; 0 when empty
- head_ferr  output  1  oldest entry's framing flag; 0 when empty
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- count  output  $clog2(DEPTH)+1  number of stored entries
- rx_int  output  1  one-cycle pulse on an empty→non-empty transition

## Operation
- Storage: DEPTH × (WIDTH+2) array holding {perr, ferr, data}. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Capture FSM has two states, IDLE and WAIT_LOW.
  - IDLE: if rxrdy && !full at a clock edge, write the entry at wr_ptr, increment wr_ptr, set rx_read for the next cycle, and go to WAIT_LOW.
  - IDLE: if rxrdy && full, stay in IDLE, write nothing, and leave rx_read low. The character remains in the RX engine, which sets its own OVF if another arrives.
  - WAIT_LOW: rx_read is 0. Return to IDLE on the first edge that samples rxrdy low. No capture occurs in this state.
- Pop: if pop && !empty, increment rd_ptr. If pop && empty, do nothing; count stays 0 and there is no underflow.
- Head outputs are combinational from mem[rd_ptr], gated to 0 when empty.
- count is +1 on push only, −1 on pop only, and unchanged when both occur.
- rx_int is registered. It is 1 for exactly one cycle after an edge at which count went from 0 to ≥ 1.

## Timing
- Reset values:
  - rx_read=0, rx_int=0, count=0, empty=1, full=0
  - head_data/perr/ferr = 0
  - state=IDLE, pointers=0
  - Memory contents are not reset.
- Push latency: rxrdy is sampled high at edge k. rx_read is high during cycle k→k+1. head and count reflect the new entry after edge k.
- RX engine clears rxrdy in response to rx_read, so it is seen low at edge k+1 or later. The earliest next capture is at edge k+2.
- Pop: entry removed at the edge sampling pop. The next entry, or zeros, is visible immediately after that edge.
- Simultaneous push and pop when empty: the pop is ignored and the push completes, so count=1 and rx_int pulses.
- Simultaneous push and pop when full: push is blocked because full is sampled before the pop. The pop completes and the capture happens at the following edge.
- Simultaneous push and pop with 0<count<DEPTH: both complete and count is unchanged.
- Reset mid-operation: all state clears immediately. If rx_read was high, it drops at once. A character still pending in the RX engine is captured after reset is released.

## Structure
- Shared package uart_pkg:
  - capture FSM state encoding (IDLE, WAIT_LOW)
  - UART_RX_FIFO_DEPTH default constant
  - entry-width localparam (WIDTH+2)
- One sub-module is natural: uart_fifo_mem, a synchronous-write, asynchronous-read register array with parameters DEPTH and W.
- The top level holds the pointers, count, FSM and interrupt register.

## Test plan
- Reset, then a single char: rx_data=8'h41, perr=0, ferr=0, rxrdy raised.
  - rx_read high for exactly 1 cycle.
  - Then head_data=8'h41, count=1, empty=0.
  - rx_int pulses once.
- Error flags: push 8'h55 with ferr=1, then 8'h33 with perr=1.
  - head shows 55/ferr=1.
  - After pop, head shows 33/perr=1.
  - After a second pop, head=0 and empty=1.
- Fill: push 16 chars 8'h00..8'h0F.
  - full=1 and count=16.
  - A 17th rxrdy gets no rx_read while full.
  - One pop: the 17th char is captured on the following edges, count=16, and head=8'h01.
- Wrap: push 10 and pop 10, three times, with values incrementing.
  - Pop order always matches push order across the pointer wrap.
  - count is 0 at the end.
- Same-cycle push and pop at count=3: count stays 3 and no rx_int. Pop on empty: count stays 0 and outputs stay 0.
- Reset asserted while rx_read is high and count=5: immediately rx_read=0, count=0, empty=1 and head=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side buffer.
package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } cap_state_e;

    localparam int UART_RX_FIFO_DEPTH = 16;
    localparam int UART_RX_WIDTH      = 8;
    localparam int UART_ENTRY_W       = UART_RX_WIDTH + 2;

    // Stored entry is {perr, ferr, data}
    function automatic int entry_w(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register array: synchronous write, asynchronous read.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 10
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Contents are deliberately left unreset; head outputs are gated when empty
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through buffer draining the UART RX holding register,
// with a one-cycle interrupt on the empty to non-empty transition.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int WIDTH = UART_RX_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       rx_data,
    input  logic                   rx_perr,
    input  logic                   rx_ferr,
    input  logic                   rxrdy,
    output logic                   rx_read,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   head_perr,
    output logic                   head_ferr,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   rx_int
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_w(WIDTH);

    cap_state_e    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rx_read_q, rx_read_d;
    logic          rx_int_q, rx_int_d;
    logic          push, pop_ok;
    logic [EW-1:0] rd_entry;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign pop_ok = pop && !empty;

    // Capture once per rxrdy high phase; WAIT_LOW waits for the engine to clear it
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rxrdy && !full) begin
                    push    = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!rxrdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d  = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rx_read_d = push;
        // A push while empty can never coincide with a real pop
        rx_int_d  = push && empty;
        count_d   = count_q;
        case ({push, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rx_read_q <= 1'b0;
            rx_int_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rx_read_q <= rx_read_d;
            rx_int_q  <= rx_int_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({rx_perr, rx_ferr, rx_data}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign head_data = empty ? '0   : rd_entry[WIDTH-1:0];
    assign head_ferr = empty ? 1'b0 : rd_entry[EW-2];
    assign head_perr = empty ? 1'b0 : rd_entry[EW-1];
    assign count     = count_q;
    assign rx_read   = rx_read_q;
    assign rx_int    = rx_int_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus hand-written corner sequences.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_perr, rx_ferr, rxrdy, pop;
    logic       rx_read, head_perr, head_ferr, empty, full, rx_int;
    logic [7:0] head_data;
    logic [4:0] count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_perr   (rx_perr),
        .rx_ferr   (rx_ferr),
        .rxrdy     (rxrdy),
        .rx_read   (rx_read),
        .pop       (pop),
        .head_data (head_data),
        .head_perr (head_perr),
        .head_ferr (head_ferr),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .rx_int    (rx_int)
    );

    typedef struct packed {
        logic       push;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       pop;
        logic [4:0] cnt;
        logic [7:0] hd;
        logic       hp;
        logic       hf;
        logic       emp;
        logic       rd;
        logic       irq;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One capture handshake: engine raises rxrdy, drops it after seeing rx_read
    task automatic push_chr(input logic [7:0] d, input logic pe, input logic fe);
        rx_data = d; rx_perr = pe; rx_ferr = fe; rxrdy = 1'b1;
        step();
        check("push_rx_read", rx_read, 1);
        rxrdy = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; rx_data = '0; rx_perr = 0; rx_ferr = 0; rxrdy = 0; pop = 0;

        //           push d      pe fe pop cnt hd     hp hf emp rd irq
        vt[0]  = '{1'b0, 8'h00, 0, 0, 1, 5'd0, 8'h00, 0, 0, 1, 0, 0};
        vt[1]  = '{1'b1, 8'h55, 0, 1, 0, 5'd1, 8'h55, 0, 1, 0, 1, 1};
        vt[2]  = '{1'b1, 8'h33, 1, 0, 0, 5'd2, 8'h55, 0, 1, 0, 1, 0};
        vt[3]  = '{1'b0, 8'h00, 0, 0, 1, 5'd1, 8'h33, 1, 0, 0, 0, 0};
        vt[4]  = '{1'b0, 8'h00, 0, 0, 1, 5'd0, 8'h00, 0, 0, 1, 0, 0};
        vt[5]  = '{1'b0, 8'h00, 0, 0, 1, 5'd0, 8'h00, 0, 0, 1, 0, 0};
        vt[6]  = '{1'b1, 8'hA1, 0, 0, 0, 5'd1, 8'hA1, 0, 0, 0, 1, 1};
        vt[7]  = '{1'b1, 8'hA2, 0, 0, 0, 5'd2, 8'hA1, 0, 0, 0, 1, 0};
        vt[8]  = '{1'b1, 8'hA3, 0, 0, 0, 5'd3, 8'hA1, 0, 0, 0, 1, 0};
        vt[9]  = '{1'b1, 8'hA4, 0, 0, 1, 5'd3, 8'hA2, 0, 0, 0, 1, 0};
        vt[10] = '{1'b0, 8'h00, 0, 0, 1, 5'd2, 8'hA3, 0, 0, 0, 0, 0};
        vt[11] = '{1'b0, 8'h00, 0, 0, 1, 5'd1, 8'hA4, 0, 0, 0, 0, 0};
        vt[12] = '{1'b0, 8'h00, 0, 0, 1, 5'd0, 8'h00, 0, 0, 1, 0, 0};
        vt[13] = '{1'b1, 8'hB7, 1, 1, 1, 5'd1, 8'hB7, 1, 1, 0, 1, 1};
        vt[14] = '{1'b0, 8'h00, 0, 0, 1, 5'd0, 8'h00, 0, 0, 1, 0, 0};

        step(); step();
        check("rst_rx_read", rx_read, 0);
        check("rst_rx_int", rx_int, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_head", {head_perr, head_ferr, head_data}, 0);
        reset = 1'b0;

        // Single character
        rx_data = 8'h41; rxrdy = 1'b1;
        step();
        check("c1_rx_read", rx_read, 1);
        check("c1_rx_int", rx_int, 1);
        check("c1_count", count, 1);
        check("c1_head", head_data, 8'h41);
        check("c1_empty", empty, 0);
        rxrdy = 1'b0;
        step();
        check("c1_rx_read_drop", rx_read, 0);
        check("c1_rx_int_drop", rx_int, 0);
        step();
        check("c1_rx_read_low", rx_read, 0);
        check("c1_count_hold", count, 1);

        for (int i = 0; i < 15; i++) begin
            rx_data = vt[i].d; rx_perr = vt[i].pe; rx_ferr = vt[i].fe;
            rxrdy = vt[i].push; pop = vt[i].pop;
            step();
            check($sformatf("v%0d_count", i), count, vt[i].cnt);
            check($sformatf("v%0d_head", i), {head_perr, head_ferr, head_data},
                  {vt[i].hp, vt[i].hf, vt[i].hd});
            check($sformatf("v%0d_empty", i), empty, vt[i].emp);
            check($sformatf("v%0d_rx_read", i), rx_read, vt[i].rd);
            check($sformatf("v%0d_rx_int", i), rx_int, vt[i].irq);
            rxrdy = 1'b0; pop = 1'b0;
            step();
            check($sformatf("v%0d_idle_irq", i), rx_int, 0);
        end
        rx_perr = 0; rx_ferr = 0;

        // Fill to DEPTH, then a blocked 17th character
        for (int i = 0; i < 16; i++) push_chr(8'(i), 0, 0);
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        rx_data = 8'h10; rxrdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_no_rx_read", rx_read, 0);
            check("full_count", count, 16);
        end
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("full_pop_count", count, 15);
        check("full_pop_rx_read", rx_read, 0);
        check("full_pop_head", head_data, 8'h01);
        step();
        check("late_rx_read", rx_read, 1);
        check("late_count", count, 16);
        rxrdy = 1'b0;
        step();
        check("late_head", head_data, 8'h01);
        check("late_full", full, 1);
        pop = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("drain_head", head_data, 8'(i));
            step();
        end
        pop = 1'b0;
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);

        // Pointer wrap: 3 rounds of 10 in, 10 out
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 10; j++) push_chr(8'(8'h20 + r * 10 + j), 0, 0);
            check("wrap_count10", count, 10);
            pop = 1'b1;
            for (int j = 0; j < 10; j++) begin
                check("wrap_head", head_data, 8'(8'h20 + r * 10 + j));
                step();
            end
            pop = 1'b0;
        end
        check("wrap_count0", count, 0);
        check("wrap_empty", empty, 1);

        // Reset while rx_read is high with count=5
        for (int i = 0; i < 4; i++) push_chr(8'(8'hC0 + i), 0, 0);
        rx_data = 8'hC4; rxrdy = 1'b1;
        step();
        check("pre_rst_rx_read", rx_read, 1);
        check("pre_rst_count", count, 5);
        reset = 1'b1;
        #1;
        check("mid_rst_rx_read", rx_read, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_head", head_data, 0);
        #1;
        reset = 1'b0;
        step();
        check("post_rst_rx_read", rx_read, 1);
        check("post_rst_count", count, 1);
        check("post_rst_head", head_data, 8'hC4);
        check("post_rst_rx_int", rx_int, 1);
        rxrdy = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
